// File: rtl/vdp_priority_pkg.sv
// Shared constants and helpers for the VDP layer priority compute stage.
// Imported by the resolver and the pipelined top.
package vdp_priority_pkg;

  localparam int DEF_SCROLL_LAYERS = 4;
  localparam int DEF_PIXEL_WIDTH   = 8;
  localparam int DEF_OPAQUE_BITS   = 4;
  localparam int DEF_PRIO_WIDTH    = 2;
  localparam int DEF_COUNT_WIDTH   = 10;
  localparam int SPRITE_LAYER      = DEF_SCROLL_LAYERS;
  localparam int PRIO_MAX_WIDTH    = 8;

  // Strict compare: an earlier-visited candidate keeps a tie.
  function automatic logic prio_beats(
    input logic [PRIO_MAX_WIDTH-1:0] cand,
    input logic [PRIO_MAX_WIDTH-1:0] best,
    input logic                      best_empty
  );
    return best_empty || (cand > best);
  endfunction

endpackage

// File: rtl/vdp_layer_priority_resolve.sv
// Combinational winner select across one candidate group of layers.
// Visit order sprite, scroll 0, scroll 1, ... gives the tie-break.
module vdp_layer_priority_resolve
  import vdp_priority_pkg::*;
#(
  parameter int L           = 5,
  parameter int PRIO_WIDTH  = 2,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [L-1:0]             cand,
  input  logic [L*PRIO_WIDTH-1:0]  prio,
  input  logic [L*PIXEL_WIDTH-1:0] pixels,
  output logic [L-1:0]             layer,
  output logic [PIXEL_WIDTH-1:0]   pixel,
  output logic [PRIO_WIDTH-1:0]    win_prio,
  output logic                     empty
);

  localparam int IW = $clog2(L);

  logic [PRIO_WIDTH-1:0]     prio_arr [L];
  logic [PIXEL_WIDTH-1:0]    pix_arr  [L];
  logic [IW-1:0]             idx;
  logic [IW-1:0]             best;
  logic [PRIO_MAX_WIDTH-1:0] best_prio;

  always_comb begin
    for (int k = 0; k < L; k++) begin
      prio_arr[k] = prio[k*PRIO_WIDTH +: PRIO_WIDTH];
      pix_arr[k]  = pixels[k*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

  always_comb begin
    idx       = '0;
    best      = '0;
    best_prio = '0;
    empty     = 1'b1;
    for (int k = 0; k < L; k++) begin
      if (k == 0) idx = IW'(L - 1);
      else        idx = IW'(k - 1);
      if (cand[idx] &&
          prio_beats(PRIO_MAX_WIDTH'(prio_arr[idx]), best_prio, empty)) begin
        empty     = 1'b0;
        best      = idx;
        best_prio = PRIO_MAX_WIDTH'(prio_arr[idx]);
      end
    end
  end

  always_comb begin
    layer    = '0;
    pixel    = '0;
    win_prio = best_prio[PRIO_WIDTH-1:0];
    if (!empty) begin
      layer[best] = 1'b1;
      pixel       = pix_arr[best];
    end
  end

endmodule

// File: rtl/vdp_priority_compute_pipelined.sv
// Two-stage primary/masked layer priority resolve with line-synchronous
// double-buffered config and a per-line masked-win counter.
module vdp_priority_compute_pipelined
  import vdp_priority_pkg::*;
#(
  parameter int SCROLL_LAYERS = DEF_SCROLL_LAYERS,
  parameter int PIXEL_WIDTH   = DEF_PIXEL_WIDTH,
  parameter int OPAQUE_BITS   = DEF_OPAQUE_BITS,
  parameter int PRIO_WIDTH    = DEF_PRIO_WIDTH,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
  localparam int N = SCROLL_LAYERS,
  localparam int L = SCROLL_LAYERS + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [N*PIXEL_WIDTH-1:0] scroll_pixels,
  input  logic [PIXEL_WIDTH-1:0]   sprite_pixel,
  input  logic [PRIO_WIDTH-1:0]    sprite_priority,
  input  logic                     line_start,
  input  logic                     cfg_write,
  input  logic [L-1:0]             cfg_layer_enable,
  input  logic [L-1:0]             cfg_layer_mask,
  input  logic [N*PRIO_WIDTH-1:0]  cfg_scroll_priority,
  output logic                     out_valid,
  output logic [PIXEL_WIDTH-1:0]   prioritized_pixel,
  output logic [L-1:0]             prioritized_layer,
  output logic [PIXEL_WIDTH-1:0]   prioritized_masked_pixel,
  output logic [L-1:0]             prioritized_masked_layer,
  output logic [COUNT_WIDTH-1:0]   masked_pixel_count
);

  logic [L-1:0]            shadow_enable, shadow_mask;
  logic [L-1:0]            active_enable, active_mask;
  logic [N*PRIO_WIDTH-1:0] shadow_prio, active_prio;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_enable <= '0;
      shadow_mask   <= '1;
      shadow_prio   <= '0;
      active_enable <= '0;
      active_mask   <= '1;
      active_prio   <= '0;
    end else begin
      if (cfg_write) begin
        shadow_enable <= cfg_layer_enable;
        shadow_mask   <= cfg_layer_mask;
        shadow_prio   <= cfg_scroll_priority;
      end
      if (line_start) begin
        active_enable <= cfg_write ? cfg_layer_enable : shadow_enable;
        active_mask   <= cfg_write ? cfg_layer_mask : shadow_mask;
        active_prio   <= cfg_write ? cfg_scroll_priority : shadow_prio;
      end
    end
  end

  logic [L*PIXEL_WIDTH-1:0] pix_all;
  logic [L-1:0]             opaque;

  assign pix_all = {sprite_pixel, scroll_pixels};

  always_comb begin
    for (int i = 0; i < L; i++)
      opaque[i] = |pix_all[i*PIXEL_WIDTH +: OPAQUE_BITS];
  end

  logic                     s1_valid;
  logic [L-1:0]             s1_prim_cand, s1_mask_cand;
  logic [L*PRIO_WIDTH-1:0]  s1_prio;
  logic [L*PIXEL_WIDTH-1:0] s1_pix;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid     <= 1'b0;
      s1_prim_cand <= '0;
      s1_mask_cand <= '0;
      s1_prio      <= '0;
      s1_pix       <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_prim_cand <= active_enable & opaque & active_mask;
        s1_mask_cand <= active_enable & opaque & ~active_mask;
        s1_prio      <= {sprite_priority, active_prio};
        s1_pix       <= pix_all;
      end
    end
  end

  logic [L-1:0]           p_layer, m_layer;
  logic [PIXEL_WIDTH-1:0] p_pixel, m_pixel;
  logic [PRIO_WIDTH-1:0]  p_prio, m_prio;
  logic                   p_empty, m_empty;
  logic                   force_off;

  vdp_layer_priority_resolve #(
    .L(L), .PRIO_WIDTH(PRIO_WIDTH), .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_primary (
    .cand(s1_prim_cand), .prio(s1_prio), .pixels(s1_pix),
    .layer(p_layer), .pixel(p_pixel), .win_prio(p_prio), .empty(p_empty)
  );

  vdp_layer_priority_resolve #(
    .L(L), .PRIO_WIDTH(PRIO_WIDTH), .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_masked (
    .cand(s1_mask_cand), .prio(s1_prio), .pixels(s1_pix),
    .layer(m_layer), .pixel(m_pixel), .win_prio(m_prio), .empty(m_empty)
  );

  assign force_off = !p_empty && (m_empty || (p_prio > m_prio));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid                <= 1'b0;
      prioritized_pixel        <= '0;
      prioritized_layer        <= '0;
      prioritized_masked_pixel <= '0;
      prioritized_masked_layer <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        prioritized_pixel        <= p_pixel;
        prioritized_layer        <= p_layer;
        prioritized_masked_pixel <= m_pixel;
        prioritized_masked_layer <= force_off ? '0 : m_layer;
      end
    end
  end

  // Clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      masked_pixel_count <= '0;
    end else if (line_start) begin
      masked_pixel_count <= '0;
    end else if (out_valid && |prioritized_masked_layer &&
                 masked_pixel_count != '1) begin
      masked_pixel_count <= masked_pixel_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_vdp_priority_compute_pipelined.sv
// Directed bench for the pipelined VDP priority compute stage.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vdp_priority_compute_pipelined;

  localparam logic [31:0] SCR = 32'h44332211;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] scroll_pixels;
  logic [7:0]  sprite_pixel;
  logic [1:0]  sprite_priority;
  logic        line_start;
  logic        cfg_write;
  logic [4:0]  cfg_layer_enable;
  logic [4:0]  cfg_layer_mask;
  logic [7:0]  cfg_scroll_priority;
  logic        out_valid;
  logic [7:0]  prioritized_pixel;
  logic [4:0]  prioritized_layer;
  logic [7:0]  prioritized_masked_pixel;
  logic [4:0]  prioritized_masked_layer;
  logic [9:0]  masked_pixel_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  vdp_priority_compute_pipelined dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .scroll_pixels(scroll_pixels),
    .sprite_pixel(sprite_pixel),
    .sprite_priority(sprite_priority),
    .line_start(line_start),
    .cfg_write(cfg_write),
    .cfg_layer_enable(cfg_layer_enable),
    .cfg_layer_mask(cfg_layer_mask),
    .cfg_scroll_priority(cfg_scroll_priority),
    .out_valid(out_valid),
    .prioritized_pixel(prioritized_pixel),
    .prioritized_layer(prioritized_layer),
    .prioritized_masked_pixel(prioritized_masked_pixel),
    .prioritized_masked_layer(prioritized_masked_layer),
    .masked_pixel_count(masked_pixel_count)
  );

  task automatic apply_cfg(input logic [4:0] en, input logic [4:0] mk,
                           input logic [7:0] pr);
    cfg_write = 1'b1;
    line_start = 1'b1;
    cfg_layer_enable = en;
    cfg_layer_mask = mk;
    cfg_scroll_priority = pr;
    @(negedge clk);
    cfg_write = 1'b0;
    line_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] sp, input logic [7:0] spr,
                      input logic [1:0] spp);
    in_valid = 1'b1;
    scroll_pixels = sp;
    sprite_pixel = spr;
    sprite_priority = spp;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    scroll_pixels = '0;
    sprite_pixel = '0;
    sprite_priority = '0;
    line_start = 1'b0;
    cfg_write = 1'b0;
    cfg_layer_enable = '0;
    cfg_layer_mask = '0;
    cfg_scroll_priority = '0;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL rst_valid got %b want 0", out_valid);
    else passed++;
    total++;
    if (prioritized_layer !== 5'b0 || prioritized_pixel !== 8'h0)
      $display("FAIL rst_primary got %b/%h want 0/00",
               prioritized_layer, prioritized_pixel);
    else passed++;
    total++;
    if (prioritized_masked_layer !== 5'b0 ||
        prioritized_masked_pixel !== 8'h0)
      $display("FAIL rst_masked got %b/%h want 0/00",
               prioritized_masked_layer, prioritized_masked_pixel);
    else passed++;
    total++;
    if (masked_pixel_count !== 10'd0)
      $display("FAIL rst_count got %0d want 0", masked_pixel_count);
    else passed++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    apply_cfg(5'b11111, 5'b11111, 8'b11_10_01_00);
    send(SCR, 8'h55, 2'd2);
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL basic_latency1 got %b want 0", out_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1)
      $display("FAIL basic_valid got %b want 1", out_valid);
    else passed++;
    total++;
    if (prioritized_layer !== 5'b01000 || prioritized_pixel !== 8'h44)
      $display("FAIL basic_primary got %b/%h want 01000/44",
               prioritized_layer, prioritized_pixel);
    else passed++;
    total++;
    if (prioritized_masked_layer !== 5'b0)
      $display("FAIL basic_masked got %b want 00000",
               prioritized_masked_layer);
    else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || prioritized_layer !== 5'b01000)
      $display("FAIL basic_hold got %b/%b want 0/01000",
               out_valid, prioritized_layer);
    else passed++;
  endtask

  task automatic test_sprite_tie();
    send(SCR, 8'h55, 2'd3);
    @(negedge clk);
    total++;
    if (prioritized_layer !== 5'b10000 || prioritized_pixel !== 8'h55)
      $display("FAIL sprite_tie got %b/%h want 10000/55",
               prioritized_layer, prioritized_pixel);
    else passed++;
    apply_cfg(5'b01111, 5'b11111, 8'b01_01_01_01);
    send(SCR, 8'h55, 2'd3);
    @(negedge clk);
    total++;
    if (prioritized_layer !== 5'b00001 || prioritized_pixel !== 8'h11)
      $display("FAIL scroll_tie got %b/%h want 00001/11",
               prioritized_layer, prioritized_pixel);
    else passed++;
  endtask

  task automatic test_masked();
    apply_cfg(5'b11111, 5'b11110, 8'b00_00_00_11);
    send(SCR, 8'h55, 2'd0);
    @(negedge clk);
    total++;
    if (prioritized_layer !== 5'b10000 || prioritized_pixel !== 8'h55)
      $display("FAIL masked_primary got %b/%h want 10000/55",
               prioritized_layer, prioritized_pixel);
    else passed++;
    total++;
    if (prioritized_masked_layer !== 5'b00001 ||
        prioritized_masked_pixel !== 8'h11)
      $display("FAIL masked_win got %b/%h want 00001/11",
               prioritized_masked_layer, prioritized_masked_pixel);
    else passed++;
    total++;
    if (masked_pixel_count !== 10'd0)
      $display("FAIL masked_count0 got %0d want 0", masked_pixel_count);
    else passed++;
    @(negedge clk);
    total++;
    if (masked_pixel_count !== 10'd1)
      $display("FAIL masked_count1 got %0d want 1", masked_pixel_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (masked_pixel_count !== 10'd4)
      $display("FAIL b2b_count got %0d want 4", masked_pixel_count);
    else passed++;
  endtask

  task automatic test_force_off();
    apply_cfg(5'b11111, 5'b11110, 8'h00);
    send(SCR, 8'h55, 2'd1);
    @(negedge clk);
    total++;
    if (prioritized_layer !== 5'b10000)
      $display("FAIL force_primary got %b want 10000", prioritized_layer);
    else passed++;
    total++;
    if (prioritized_masked_layer !== 5'b0 ||
        prioritized_masked_pixel !== 8'h11)
      $display("FAIL force_masked got %b/%h want 00000/11",
               prioritized_masked_layer, prioritized_masked_pixel);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (masked_pixel_count !== 10'd0)
      $display("FAIL force_count got %0d want 0", masked_pixel_count);
    else passed++;
  endtask

  task automatic test_transparent();
    send(32'hF0F0F0F0, 8'hF0, 2'd3);
    @(negedge clk);
    total++;
    if (prioritized_layer !== 5'b0 || prioritized_pixel !== 8'h0)
      $display("FAIL transp_primary got %b/%h want 00000/00",
               prioritized_layer, prioritized_pixel);
    else passed++;
    total++;
    if (prioritized_masked_layer !== 5'b0 ||
        prioritized_masked_pixel !== 8'h0)
      $display("FAIL transp_masked got %b/%h want 00000/00",
               prioritized_masked_layer, prioritized_masked_pixel);
    else passed++;
  endtask

  task automatic test_shadow();
    cfg_write = 1'b1;
    cfg_layer_enable = 5'b00001;
    cfg_layer_mask = 5'b11111;
    cfg_scroll_priority = 8'h00;
    @(negedge clk);
    cfg_write = 1'b0;
    send(SCR, 8'h55, 2'd1);
    @(negedge clk);
    total++;
    if (prioritized_layer !== 5'b10000 || prioritized_pixel !== 8'h55)
      $display("FAIL shadow_old got %b/%h want 10000/55",
               prioritized_layer, prioritized_pixel);
    else passed++;
    line_start = 1'b1;
    send(SCR, 8'h55, 2'd1);
    line_start = 1'b0;
    total++;
    if (masked_pixel_count !== 10'd0)
      $display("FAIL shadow_count got %0d want 0", masked_pixel_count);
    else passed++;
    @(negedge clk);
    total++;
    if (prioritized_layer !== 5'b10000)
      $display("FAIL same_cycle_ls got %b want 10000", prioritized_layer);
    else passed++;
    send(SCR, 8'h55, 2'd1);
    @(negedge clk);
    total++;
    if (prioritized_layer !== 5'b00001 || prioritized_pixel !== 8'h11 ||
        prioritized_masked_layer !== 5'b0)
      $display("FAIL shadow_new got %b/%h/%b want 00001/11/00000",
               prioritized_layer, prioritized_pixel,
               prioritized_masked_layer);
    else passed++;
  endtask

  task automatic test_saturate();
    apply_cfg(5'b11111, 5'b11110, 8'b00_00_00_11);
    scroll_pixels = SCR;
    sprite_pixel = 8'h55;
    sprite_priority = 2'd0;
    in_valid = 1'b1;
    repeat (1029) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (masked_pixel_count !== 10'h3FF)
      $display("FAIL sat_count got %0d want 1023", masked_pixel_count);
    else passed++;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    total++;
    if (masked_pixel_count !== 10'd0)
      $display("FAIL clear_prio got %0d want 0", masked_pixel_count);
    else passed++;
    @(negedge clk);
    total++;
    if (masked_pixel_count !== 10'd1)
      $display("FAIL clear_resume got %0d want 1", masked_pixel_count);
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || prioritized_layer !== 5'b0 ||
        prioritized_pixel !== 8'h0)
      $display("FAIL midrst_primary got %b/%b/%h want 0/00000/00",
               out_valid, prioritized_layer, prioritized_pixel);
    else passed++;
    total++;
    if (prioritized_masked_layer !== 5'b0 ||
        prioritized_masked_pixel !== 8'h0 ||
        masked_pixel_count !== 10'd0)
      $display("FAIL midrst_masked got %b/%h/%0d want 00000/00/0",
               prioritized_masked_layer, prioritized_masked_pixel,
               masked_pixel_count);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL midrst_flush got %b want 0", out_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1)
      $display("FAIL midrst_resume got %b want 1", out_valid);
    else passed++;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sprite_tie();
    test_masked();
    test_back_to_back();
    test_force_off();
    test_transparent();
    test_shadow();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
